lsu_mem_ctrl: RTL
=================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port req_valid, input, 1, load/store request present.
REQ-004 SHALL have port req_ready, output, 1, request accepted on an edge where req_valid && req_ready.
REQ-005 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3, RISC-V width code: loads LB=0, LH=1, LW=2, LBU=4, LHU=5; stores SB=0, SH=1, SW=2.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port resp_valid, output, 1, one-cycle completion pulse; no backpressure.
REQ-010 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-011 SHALL have port resp_err, output, 1, valid with resp_valid: misaligned, out-of-range or illegal funct3.
REQ-012 SHALL have port m_addr, output, 32, word address to data memory.
REQ-013 SHALL have port m_wr_dat, output, 32, word write data.
REQ-014 SHALL have port rd_en, output, 1, memory read strobe; memory returns m_rd_dat on the following cycle.
REQ-015 SHALL have port wr_en, output, 1, memory word write strobe.
REQ-016 SHALL have port m_rd_dat, input, 32, registered read data from memory.

Function
REQ-017 SHALL implement states IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_WR; req_ready = 1 only in IDLE with reset low.
REQ-018 SHALL drive m_addr = {2'b0, addr[31:2]} from the captured request; m_addr, m_wr_dat = 0 and rd_en, wr_en = 0 in IDLE.
REQ-019 SHALL flag error when: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; addr[31:12]!=0 (memory = 1024 words); load funct3 in {3,6,7}; store funct3 > 2.
REQ-020 Error request: no rd_en/wr_en; resp_valid=1, resp_err=1, resp_rdata=0 in cycle after acceptance edge; state stays IDLE.
REQ-021 Load: IDLE->LD_RD (rd_en=1, one cycle)->LD_CAP->IDLE; resp_valid high in the cycle after LD_CAP, i.e. 3 cycles after the acceptance cycle.
REQ-022 Load extraction: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-023 SW: IDLE->ST_WR (wr_en=1, m_wr_dat=req_wdata, one cycle)->IDLE; resp_valid in the following cycle; no rd_en.
REQ-024 SB/SH: IDLE->RMW_RD (rd_en=1)->RMW_WR (wr_en=1, m_wr_dat = m_rd_dat with addressed lane replaced by req_wdata[7:0] / [15:0])->IDLE; resp_valid in the following cycle.
REQ-025 rd_en and wr_en SHALL never be high in the same cycle; each strobe lasts exactly one cycle per access.
REQ-026 Requests arriving while req_ready=0 SHALL be ignored; a new request may be accepted in the same cycle resp_valid is high.

Reset
REQ-027 On reset: state=IDLE; req_ready, resp_valid, resp_err, rd_en, wr_en = 0; resp_rdata, m_addr, m_wr_dat = 0.
REQ-028 Reset mid-operation SHALL abort without a response; reset in RMW_RD SHALL prevent any wr_en, leaving memory unchanged.
REQ-029 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Package lsu_pkg SHALL hold the funct3 constants, the state enum and MEM_WORDS=1024.
REQ-031 Combinational sub-module lsu_align SHALL hold load extraction/extension and store lane merge; lsu_mem_ctrl holds the FSM and registers.

Verification (memory word 0x10 preloaded 0x8081F2F3)
REQ-032 LB addr 0x43 -> one rd_en with m_addr=0x10; resp_rdata=0xFFFFFF80 3 cycles after acceptance cycle; resp_err=0.
REQ-033 LHU 0x42 -> 0x00008081; LH 0x40 -> 0xFFFFF2F3; LBU 0x41 -> 0x000000F2.
REQ-034 SB addr 0x41, wdata 0x123456AA -> rd_en cycle then wr_en cycle with m_wr_dat=0x8081AAF3; then LW 0x40 -> 0x8081AAF3.
REQ-035 SW addr 0x44, wdata 0xDEADBEEF -> single wr_en, m_addr=0x11, no rd_en; resp_valid next cycle.
REQ-036 LW 0x42, SH 0x41, LW 0x1000, load funct3=3 -> each resp_err=1, resp_rdata=0, no strobes.
REQ-037 Reset pulsed during RMW_RD of SB -> no wr_en, no resp_valid, word 0x10 unchanged, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, controller
// states, memory geometry and the request legality rule.
package lsu_pkg;

    localparam int MEM_WORDS = 1024;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_WR
    } state_t;

    // A request is illegal when it leaves the memory, is misaligned for its
    // width, or carries a width code that has no meaning for its direction.
    function automatic logic req_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [31:0] addr);
        logic bad;
        bad = (addr[31:2] >= 30'(MEM_WORDS));
        case (funct3)
            F3_B:         bad = bad;
            F3_H:         bad = bad | addr[0];
            F3_W:         bad = bad | (addr[1:0] != 2'b00);
            F3_BU:        bad = bad | we;
            F3_HU:        bad = bad | we | addr[0];
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/halfword extraction with sign or zero
// extension, and the read-modify-write merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Sub-word stores keep the neighbouring lanes of the word just read.
    always_comb begin
        store_word = rd_word;
        case (funct3)
            F3_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one request at a time, sequences word reads,
// writes and read-modify-writes against a single-port data memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_wr_dat,
    output logic        rd_en,
    output logic        wr_en,
    input  logic [31:0] m_rd_dat
);

    state_t      state, state_next;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        req_bad;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign req_bad   = req_illegal(req_we, req_funct3, req_addr);
    assign word_addr = {2'b00, addr_q[31:2]};

    lsu_align u_align (
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .rd_word    (m_rd_dat),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // Illegal requests are answered straight from IDLE without touching memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            if (accept && req_bad) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
            end else begin
                case (state)
                    LD_CAP: begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                    ST_WR, RMW_WR: resp_valid <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        m_addr     = 32'd0;
        m_wr_dat   = 32'd0;
        case (state)
            IDLE: begin
                if (accept && !req_bad) begin
                    if (!req_we)                 state_next = LD_RD;
                    else if (req_funct3 == F3_W) state_next = ST_WR;
                    else                         state_next = RMW_RD;
                end
            end
            LD_RD: begin
                rd_en      = 1'b1;
                m_addr     = word_addr;
                state_next = LD_CAP;
            end
            LD_CAP: begin
                m_addr     = word_addr;
                state_next = IDLE;
            end
            ST_WR: begin
                wr_en      = 1'b1;
                m_addr     = word_addr;
                m_wr_dat   = store_word;
                state_next = IDLE;
            end
            RMW_RD: begin
                rd_en      = 1'b1;
                m_addr     = word_addr;
                state_next = RMW_WR;
            end
            RMW_WR: begin
                wr_en      = 1'b1;
                m_addr     = word_addr;
                m_wr_dat   = store_word;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Strobes are squashed while reset is held so an aborted RMW never writes.
        if (reset) begin
            state_next = IDLE;
            rd_en      = 1'b0;
            wr_en      = 1'b0;
            m_addr     = 32'd0;
            m_wr_dat   = 32'd0;
        end
    end

endmodule
